palette_ram_rgb: RTL and testbench

PALETTE_RAM_RGB -- requirements
Module: palette_ram_rgb

---
 rtl/palette_pkg.sv | 25 ++
 rtl/palette_mem.sv | 52 +++++
 rtl/palette_ram_rgb.sv | 82 ++++++++
 tb/tb_palette_ram_rgb.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// palette_pkg : shared types and reset palette for palette_ram_rgb
// Rev 1.0
// ---------------------------------------------------------------------------
package palette_pkg;

  localparam int LATENCY = 2;
  localparam int DEFAULT_COLOR_W = 8;

  typedef struct packed {
    logic [DEFAULT_COLOR_W-1:0] R;
    logic [DEFAULT_COLOR_W-1:0] G;
    logic [DEFAULT_COLOR_W-1:0] B;
  } rgb_t;

  localparam rgb_t PALETTE_DEFAULT [16] = '{
    24'h0000FF, 24'h9C2E99, 24'h5E2464, 24'hB4FF00,
    24'hF2E571, 24'hA9814A, 24'hDAEFDE, 24'h294656,
    24'hA9BDC5, 24'h990000, 24'h000099, 24'h00FFFF,
    24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h0000FF
  };

endpackage
`default_nettype wire

// File: rtl/palette_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// palette_mem : register-array palette, 1 write port, 1 async read port
// Rev 1.0
// ---------------------------------------------------------------------------
module palette_mem
  import palette_pkg::*;
#(
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [3*COLOR_W-1:0] wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic [3*COLOR_W-1:0] rdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [3*COLOR_W-1:0] mem [DEPTH];

  // Fit an 8-bit default channel into COLOR_W bits, MSB-aligned.
  function automatic logic [COLOR_W-1:0] scale(input logic [7:0] c);
    logic [COLOR_W+7:0] t;
    t = {c, COLOR_W'(0)};
    return t[COLOR_W+7 -: COLOR_W];
  endfunction

  function automatic logic [3*COLOR_W-1:0] init_word(input int i);
    logic [3:0] k;
    rgb_t       d;
    k = i[3:0];
    d = PALETTE_DEFAULT[k];
    if (i < 16) return {scale(d.R), scale(d.G), scale(d.B)};
    return '1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/palette_ram_rgb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// palette_ram_rgb : 2-stage palette lookup with transparency and dimming
// Rev 1.0
// ---------------------------------------------------------------------------
module palette_ram_rgb
  import palette_pkg::*;
#(
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 pix_valid_in,
  input  logic [IDX_W-1:0]     colorIdx,
  input  logic [IDX_W-1:0]     backcolorIdx,
  input  logic                 transp_en,
  input  logic [1:0]           bright_shift,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [3*COLOR_W-1:0] wr_rgb,
  output logic [COLOR_W-1:0]   R,
  output logic [COLOR_W-1:0]   G,
  output logic [COLOR_W-1:0]   B,
  output logic                 pix_valid_out
);

  logic [IDX_W-1:0]     eff_idx;
  logic                 v1;
  logic [3*COLOR_W-1:0] mem_word;
  logic [3*COLOR_W-1:0] rd_word;
  logic                 fwd_hit;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      eff_idx <= '0;
      v1      <= 1'b0;
    end else begin
      eff_idx <= (transp_en && colorIdx == '0) ? backcolorIdx : colorIdx;
      v1      <= pix_valid_in;
    end
  end

  palette_mem #(
    .IDX_W   (IDX_W),
    .COLOR_W (COLOR_W)
  ) u_mem (
    .clk   (Clk),
    .rst   (Reset),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_rgb),
    .raddr (eff_idx),
    .rdata (mem_word)
  );

  // Write-first: a same-cycle write to the entry being read wins.
  assign fwd_hit = wr_en && (wr_addr == eff_idx);
  assign rd_word = fwd_hit ? wr_rgb : mem_word;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      R             <= '0;
      G             <= '0;
      B             <= '0;
      pix_valid_out <= 1'b0;
    end else begin
      pix_valid_out <= v1;
      if (v1) begin
        R <= rd_word[3*COLOR_W-1 -: COLOR_W] >> bright_shift;
        G <= rd_word[2*COLOR_W-1 -: COLOR_W] >> bright_shift;
        B <= rd_word[COLOR_W-1   -: COLOR_W] >> bright_shift;
      end else begin
        R <= '0;
        G <= '0;
        B <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_palette_ram_rgb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_palette_ram_rgb : directed self-checking bench, IDX_W=4 and IDX_W=5 DUTs
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_palette_ram_rgb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pv  = 1'b0;
  logic [4:0]  ci  = '0;
  logic [4:0]  bi  = '0;
  logic        te  = 1'b0;
  logic [1:0]  bs  = '0;
  logic        we  = 1'b0;
  logic [4:0]  wa  = '0;
  logic [23:0] wd  = '0;

  logic [7:0] r4, g4, b4, r5, g5, b5;
  logic       v4, v5;

  int checks   = 0;
  int failures = 0;

  logic [23:0] pal [16] = '{
    24'h0000FF, 24'h9C2E99, 24'h5E2464, 24'hB4FF00,
    24'hF2E571, 24'hA9814A, 24'hDAEFDE, 24'h294656,
    24'hA9BDC5, 24'h990000, 24'h000099, 24'h00FFFF,
    24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h0000FF
  };

  always #5 clk = ~clk;

  palette_ram_rgb #(.IDX_W(4), .COLOR_W(8)) dut4 (
    .Clk(clk), .Reset(rst), .pix_valid_in(pv),
    .colorIdx(ci[3:0]), .backcolorIdx(bi[3:0]), .transp_en(te),
    .bright_shift(bs), .wr_en(we), .wr_addr(wa[3:0]), .wr_rgb(wd),
    .R(r4), .G(g4), .B(b4), .pix_valid_out(v4)
  );

  palette_ram_rgb #(.IDX_W(5), .COLOR_W(8)) dut5 (
    .Clk(clk), .Reset(rst), .pix_valid_in(pv),
    .colorIdx(ci), .backcolorIdx(bi), .transp_en(te),
    .bright_shift(bs), .wr_en(we), .wr_addr(wa), .wr_rgb(wd),
    .R(r5), .G(g5), .B(b5), .pix_valid_out(v5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] o4();
    return {7'b0, v4, r4, g4, b4};
  endfunction

  function automatic logic [31:0] o5();
    return {7'b0, v5, r5, g5, b5};
  endfunction

  function automatic logic [31:0] vis(input logic [23:0] rgb);
    return {8'h01, rgb};
  endfunction

  // Present one pixel, then idle; outputs are valid two edges later.
  task automatic pixel(input logic [4:0] idx);
    ci = idx; pv = 1'b1;
    step();
    pv = 1'b0;
    step();
  endtask

  initial begin
    step(); step();
    check("reset_out4", o4(), 32'h0);
    check("reset_out5", o5(), 32'h0);
    rst = 1'b0;
    step();

    ci = 5'd1; pv = 1'b1;
    step();
    check("latency_1cyc", o4(), 32'h0);
    pv = 1'b0;
    step();
    check("idx1", o4(), vis(24'h9C2E99));

    te = 1'b1; bi = 5'd7;
    pixel(5'd0);
    check("transp_bg7", o4(), vis(24'h294656));
    bi = 5'd0;
    pixel(5'd0);
    check("transp_bg0", o4(), vis(24'h0000FF));
    te = 1'b0; bi = 5'd7;
    pixel(5'd0);
    check("opaque_idx0", o4(), vis(24'h0000FF));

    we = 1'b1; wa = 5'd5; wd = 24'h123456;
    step();
    we = 1'b0;
    pixel(5'd5);
    check("write_read5", o4(), vis(24'h123456));

    ci = 5'd6; pv = 1'b1;
    step();
    pv = 1'b0; we = 1'b1; wa = 5'd6; wd = 24'h123456;
    step();
    we = 1'b0;
    check("forward6", o4(), vis(24'h123456));

    ci = 5'd8; pv = 1'b1;
    step();
    pv = 1'b0; we = 1'b1; wa = 5'd9; wd = 24'hFFFFFF;
    step();
    we = 1'b0;
    check("other_addr_write", o4(), vis(24'hA9BDC5));

    ci = 5'd13; pv = 1'b1; bs = 2'd0;
    step();
    pv = 1'b0; bs = 2'd2;
    step();
    bs = 2'd0;
    check("dim_shift2", o4(), vis(24'h3F0000));

    ci = 5'd3; pv = 1'b0;
    step(); step();
    check("blank_invalid", o4(), 32'h0);

    for (int i = 10; i <= 15; i++) begin
      ci = 5'(i); pv = 1'b1;
      step();
      if (i > 10) check("stream", o4(), vis(pal[i-1]));
    end
    pv = 1'b0;
    step();
    check("stream_last", o4(), vis(24'h0000FF));
    step();
    check("stream_drain", o4(), 32'h0);

    pixel(5'd20);
    check("w5_idx20", o5(), vis(24'hFFFFFF));
    we = 1'b1; wa = 5'd31; wd = 24'h0A0B0C;
    step();
    we = 1'b0;
    pixel(5'd31);
    check("w5_idx31", o5(), vis(24'h0A0B0C));

    for (int i = 0; i < 8; i++) begin
      ci = 5'(i); pv = 1'b1;
      step();
    end
    #3 rst = 1'b1;
    #1;
    check("async_rst4", o4(), 32'h0);
    check("async_rst5", o5(), 32'h0);
    we = 1'b1; wa = 5'd5; wd = 24'h000000;
    step();
    rst = 1'b0; we = 1'b0; pv = 1'b0;
    step();
    check("no_stale_1", o4(), 32'h0);
    step();
    check("no_stale_2", o4(), 32'h0);

    pixel(5'd5);
    check("revert5", o4(), vis(24'hA9814A));
    pixel(5'd6);
    check("revert6", o4(), vis(24'hDAEFDE));
    pixel(5'd31);
    check("w5_revert31", o5(), vis(24'hFFFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
